// File: rtl/demux4_router.sv
// demux4_router: routes one input stream to four independent output
// channels. Each channel is a one-entry holding register with a
// registered valid flag and a per-channel delivered-word counter.
module demux4_router #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic [WIDTH-1:0]    in_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*WIDTH-1:0]  out_data,
  input  logic                cnt_clr,
  output logic [4*CNTW-1:0]   cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e          state_q [4];
  chan_state_e          state_d [4];
  logic [WIDTH-1:0]     data_q  [4];
  logic [WIDTH-1:0]     data_d  [4];
  logic [CNTW-1:0]      cnt_q   [4];
  logic [CNTW-1:0]      cnt_d   [4];

  // Accept when the selected channel is empty or draining this cycle; held
  // low during reset so no handshake can be seen by the source.
  always_comb begin
    in_ready = reset_n & ((state_q[in_sel] == EMPTY) | out_ready[in_sel]);
  end

  // Per-channel next state: a load wins over a drain so that a simultaneous
  // drain and load leaves the channel full with the new word.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      cnt_d[k]   = cnt_q[k];

      if ((state_q[k] == FULL) && out_ready[k]) begin
        state_d[k] = EMPTY;
        cnt_d[k]   = cnt_q[k] + CNTW'(1);
      end

      if (in_valid && in_ready && (in_sel == 2'(k))) begin
        state_d[k] = FULL;
        data_d[k]  = in_data;
      end

      if (cnt_clr) begin
        cnt_d[k] = '0;
      end
    end
  end

  // Channel state, holding registers and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        // NOTE: the holding registers are reset too, because out_data must
        // read as zero during reset; this is a small register file, not a
        // RAM, so the reset costs nothing structural.
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // NOTE: non-blocking assignments here so every register samples
        // the pre-edge values, independent of statement order.
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Flatten per-channel state onto the packed output ports.
  for (genvar k = 0; k < 4; k++) begin : g_out
    assign out_valid[k]                = (state_q[k] == FULL);
    assign out_data[k*WIDTH +: WIDTH]  = data_q[k];
    assign cnt[k*CNTW +: CNTW]         = cnt_q[k];
  end

endmodule

// File: tb/tb_demux4_router.sv
// tb_demux4_router: table-driven directed vectors for routing, backpressure,
// drain/load overlap, isolation and counter clear, plus hand-written
// sequences for counter wrap and mid-flight reset.
module tb_demux4_router;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [3:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic        cnt_clr;
  logic [31:0] cnt;

  int checks;
  int errors;

  demux4_router #(.WIDTH(4), .CNTW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [3:0]  d;
    logic [3:0]  ordy;
    logic        clr;
    logic        exp_ir;    // in_ready before the edge
    logic [3:0]  exp_ov;    // out_valid after the edge
    logic [15:0] exp_od;    // out_data after the edge
    logic [31:0] exp_cnt;   // cnt after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [3:0] d,
                       input logic [3:0] ordy, input logic clr);
    in_valid  = iv;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    cnt_clr   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'b0000, 1'b0);

    //            iv   sel   d     ordy     clr   ir    ov       od        cnt
    // basic routing
    vecs.push_back('{1'b1, 2'd0, 4'h1, 4'b1111, 1'b0, 1'b1, 4'b0001, 16'h0001, 32'h00000000});
    vecs.push_back('{1'b1, 2'd1, 4'h5, 4'b1111, 1'b0, 1'b1, 4'b0010, 16'h0051, 32'h00000001});
    vecs.push_back('{1'b1, 2'd2, 4'h9, 4'b1111, 1'b0, 1'b1, 4'b0100, 16'h0951, 32'h00000101});
    vecs.push_back('{1'b1, 2'd3, 4'hD, 4'b1111, 1'b0, 1'b1, 4'b1000, 16'hD951, 32'h00010101});
    vecs.push_back('{1'b0, 2'd0, 4'h6, 4'b1111, 1'b0, 1'b1, 4'b0000, 16'hD951, 32'h01010101});
    // backpressure on channel 2
    vecs.push_back('{1'b1, 2'd2, 4'hA, 4'b1011, 1'b0, 1'b1, 4'b0100, 16'hDA51, 32'h01010101});
    vecs.push_back('{1'b1, 2'd2, 4'hB, 4'b1011, 1'b0, 1'b0, 4'b0100, 16'hDA51, 32'h01010101});
    vecs.push_back('{1'b1, 2'd2, 4'hB, 4'b1011, 1'b0, 1'b0, 4'b0100, 16'hDA51, 32'h01010101});
    vecs.push_back('{1'b1, 2'd2, 4'hB, 4'b1111, 1'b0, 1'b1, 4'b0100, 16'hDB51, 32'h01020101});
    // same-cycle drain and load on channel 1
    vecs.push_back('{1'b1, 2'd1, 4'h3, 4'b0000, 1'b0, 1'b1, 4'b0110, 16'hDB31, 32'h01020101});
    vecs.push_back('{1'b1, 2'd1, 4'h7, 4'b0010, 1'b0, 1'b1, 4'b0110, 16'hDB71, 32'h01020201});
    vecs.push_back('{1'b0, 2'd1, 4'h0, 4'b1111, 1'b0, 1'b1, 4'b0000, 16'hDB71, 32'h01030301});
    // isolation: channel 0 blocked while 1..3 flow
    vecs.push_back('{1'b1, 2'd0, 4'h4, 4'b1110, 1'b0, 1'b1, 4'b0001, 16'hDB74, 32'h01030301});
    vecs.push_back('{1'b1, 2'd1, 4'h6, 4'b1110, 1'b0, 1'b1, 4'b0011, 16'hDB64, 32'h01030301});
    vecs.push_back('{1'b1, 2'd2, 4'h8, 4'b1110, 1'b0, 1'b1, 4'b0101, 16'hD864, 32'h01030401});
    vecs.push_back('{1'b1, 2'd3, 4'hC, 4'b1110, 1'b0, 1'b1, 4'b1001, 16'hC864, 32'h01040401});
    vecs.push_back('{1'b1, 2'd0, 4'hE, 4'b1110, 1'b0, 1'b0, 4'b0001, 16'hC864, 32'h02040401});
    vecs.push_back('{1'b1, 2'd0, 4'hE, 4'b1111, 1'b0, 1'b1, 4'b0001, 16'hC86E, 32'h02040402});
    vecs.push_back('{1'b0, 2'd0, 4'h0, 4'b1111, 1'b0, 1'b1, 4'b0000, 16'hC86E, 32'h02040403});
    // clear wins over a same-cycle delivery
    vecs.push_back('{1'b1, 2'd1, 4'h2, 4'b1111, 1'b0, 1'b1, 4'b0010, 16'hC82E, 32'h02040403});
    vecs.push_back('{1'b0, 2'd1, 4'h0, 4'b1111, 1'b1, 1'b1, 4'b0000, 16'hC82E, 32'h00000000});

    // reset state
    tick();
    tick();
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset cnt", cnt, 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].ordy, vecs[i].clr);
      #3;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      tick();
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
      check($sformatf("v%0d cnt", i), cnt, vecs[i].exp_cnt);
    end

    // counter wrap: 256 back-to-back deliveries on channel 3
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'd3, 4'(i), 4'b1111, 1'b0);
      tick();
    end
    check("wrap cnt after 255", cnt, 32'hFF000000);
    check("wrap data ch3", 32'(out_data[15:12]), 32'hF);
    drive(1'b0, 2'd3, 4'h0, 4'b1111, 1'b0);
    tick();
    check("wrap cnt after 256", cnt, 32'h00000000);
    check("wrap out_valid", 32'(out_valid), 32'h0);

    // fill all channels, then reset between edges
    drive(1'b1, 2'd0, 4'h1, 4'b0000, 1'b0); tick();
    drive(1'b1, 2'd1, 4'h2, 4'b0000, 1'b0); tick();
    drive(1'b1, 2'd2, 4'h3, 4'b0000, 1'b0); tick();
    drive(1'b1, 2'd3, 4'h4, 4'b0000, 1'b0); tick();
    drive(1'b1, 2'd0, 4'h9, 4'b0001, 1'b0); tick();
    check("full out_valid", 32'(out_valid), 32'hF);
    check("full out_data", 32'(out_data), 32'h4329);
    check("full cnt", cnt, 32'h00000001);
    drive(1'b1, 2'd1, 4'h5, 4'b0000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'h0);
    check("async rst out_data", 32'(out_data), 32'h0);
    check("async rst cnt", cnt, 32'h0);
    check("async rst in_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 2'd1, 4'h5, 4'b1111, 1'b0);
    tick();
    check("held rst out_valid", 32'(out_valid), 32'h0);
    #3;
    reset_n = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 4'b1111, 1'b0);
    tick();
    check("post rst no stale valid", 32'(out_valid), 32'h0);
    check("post rst no stale data", 32'(out_data), 32'h0);
    drive(1'b1, 2'd2, 4'h6, 4'b1111, 1'b0);
    #3;
    check("post rst in_ready", 32'(in_ready), 32'h1);
    tick();
    check("post rst out_valid", 32'(out_valid), 32'h4);
    check("post rst out_data", 32'(out_data), 32'h0600);
    check("post rst cnt", cnt, 32'h0);
    drive(1'b0, 2'd0, 4'h0, 4'b1111, 1'b0);
    tick();
    check("post rst drain cnt", cnt, 32'h00010000);
    check("post rst drain valid", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
